mips_mc_control_hs: RTL and testbench

//  Next-gen multicycle MIPS32 control FSM. Sits between the IR opcode/funct fields and the datapath.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mips_mc_control_hs_if.sv | 41 ++++
 rtl/mips_alu_decoder.sv | 57 +++++
 rtl/mips_mc_control_hs.sv | 208 ++++++++++++++++++++
 tb/tb_mips_mc_control_hs.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, opcodes, funct codes and ALU codes for the multicycle controller
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_IMM} aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_control_hs_if.sv
// rtl/mips_mc_control_hs_if.sv - IR fields, memory handshake and datapath control bundle
interface mips_mc_control_hs_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 mem_ready;
  logic                 overflow;
  logic                 mem_req;
  logic                 MemWrite;
  logic                 IorD;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 ExtSel;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 Branch;
  logic                 BranchNE;
  logic [1:0]           PCSrc;
  logic                 RegWrite;
  logic                 RegDst;
  logic                 MemtoReg;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 EPCWrite;
  logic                 illegal_op;
  logic                 bus_error;

  modport master (
    input  op, funct, mem_ready, overflow,
    output mem_req, MemWrite, IorD, ALUSrcA, ALUSrcB, ExtSel, IRWrite, PCWrite,
           Branch, BranchNE, PCSrc, RegWrite, RegDst, MemtoReg, ALUControl,
           EPCWrite, illegal_op, bus_error
  );

  modport slave (
    output op, funct, mem_ready, overflow,
    input  mem_req, MemWrite, IorD, ALUSrcA, ALUSrcB, ExtSel, IRWrite, PCWrite,
           Branch, BranchNE, PCSrc, RegWrite, RegDst, MemtoReg, ALUControl,
           EPCWrite, illegal_op, bus_error
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps ALU operation class plus op/funct to ALUControl, ExtSel and legality
module mips_alu_decoder
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W    = 3,
  parameter int EN_LOGIC_IMM = 1
) (
  input  aluop_t               aluop_i,
  input  logic [5:0]           op_i,
  input  logic [5:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic                 ext_sel_o,
  output logic                 legal_o
);

  logic [2:0] code;

  // Unknown functs fall back to add so the ALU input stays well-defined
  always_comb begin
    code      = ALU_ADD;
    ext_sel_o = 1'b0;
    legal_o   = 1'b1;
    case (aluop_i)
      AOP_SUB: code = ALU_SUB;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: legal_o = 1'b0;
        endcase
      end
      AOP_IMM: begin
        case (op_i)
          OP_ADDI: code = ALU_ADD;
          OP_ANDI: begin
            code      = ALU_AND;
            ext_sel_o = 1'b1;
            legal_o   = (EN_LOGIC_IMM != 0);
          end
          OP_ORI: begin
            code      = ALU_OR;
            ext_sel_o = 1'b1;
            legal_o   = (EN_LOGIC_IMM != 0);
          end
          default: legal_o = 1'b0;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALUCTRL_W'(code);

endmodule

// File: rtl/mips_mc_control_hs.sv
// rtl/mips_mc_control_hs.sv - multicycle MIPS32 control FSM with memory handshake, watchdog and traps
module mips_mc_control_hs
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W    = 3,
  parameter int WAIT_LIMIT   = 16,
  parameter int EN_LOGIC_IMM = 1,
  parameter int TRAP_ILLEGAL = 1
) (
  input logic                  clk,
  input logic                  rst,
  mips_mc_control_hs_if.master bus
);

  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;
  logic                 raise_illegal;
  logic                 in_mem_wait;
  logic                 wd_expire;
  aluop_t               aluop;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                 ext_sel;
  logic                 funct_legal;

  mips_alu_decoder #(
    .ALUCTRL_W    (ALUCTRL_W),
    .EN_LOGIC_IMM (EN_LOGIC_IMM)
  ) u_alu_dec (
    .aluop_i    (aluop),
    .op_i       (bus.op),
    .funct_i    (bus.funct),
    .alu_ctrl_o (alu_ctrl),
    .ext_sel_o  (ext_sel),
    .legal_o    (funct_legal)
  );

  assign in_mem_wait = is_mem_state(state_q) && !bus.mem_ready;
  assign wd_expire   = (WAIT_LIMIT != 0) && in_mem_wait && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    raise_illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (wd_expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI:          state_d = S_IEXEC;
          OP_ANDI, OP_ORI: begin
            if (EN_LOGIC_IMM != 0) state_d = S_IEXEC;
            else raise_illegal = 1'b1;
          end
          OP_J:             state_d = S_JUMP;
          default:          raise_illegal = 1'b1;
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD, S_MEMWR: begin
        if (bus.mem_ready) state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (wd_expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (funct_legal) state_d = S_ALUWB;
        else raise_illegal = 1'b1;
      end
      S_ALUWB:  state_d = (bus.funct == FN_ADD && bus.overflow) ? S_TRAP : S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = (bus.op == OP_ADDI && bus.overflow) ? S_TRAP : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    if (raise_illegal) begin
      if (TRAP_ILLEGAL != 0) begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end
    // Counter only survives a cycle that stays in the same waiting memory state
    wait_cnt_d = (in_mem_wait && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    case (state_q)
      S_EXEC:   aluop = AOP_FUNCT;
      S_IEXEC:  aluop = AOP_IMM;
      S_BRANCH: aluop = AOP_SUB;
      default:  aluop = AOP_ADD;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IorD       = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ExtSel     = ext_sel;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.BranchNE   = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.ALUControl = alu_ctrl;
    bus.EPCWrite   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.mem_req = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXEC: bus.ALUSrcA = 1'b1;
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = !(bus.funct == FN_ADD && bus.overflow);
      end
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_IWB: bus.RegWrite = !(bus.op == OP_ADDI && bus.overflow);
      S_BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.PCSrc    = 2'b01;
        bus.Branch   = (bus.op == OP_BEQ);
        bus.BranchNE = (bus.op == OP_BNE);
      end
      S_JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      S_TRAP: begin
        bus.EPCWrite = 1'b1;
        bus.PCSrc    = 2'b11;
        bus.PCWrite  = 1'b1;
      end
      default: bus.mem_req = 1'b0;
    endcase
    if (rst) begin
      bus.mem_req  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.Branch   = 1'b0;
      bus.BranchNE = 1'b0;
      bus.RegWrite = 1'b0;
      bus.EPCWrite = 1'b0;
    end
  end

  assign bus.illegal_op = illegal_q;
  assign bus.bus_error  = bus_err_q;

endmodule

// File: tb/tb_mips_mc_control_hs.sv
// tb/tb_mips_mc_control_hs.sv - instruction-level model driven bench for two controller configurations
module tb_mips_mc_control_hs;

  logic       clk = 1'b0;
  logic       rst;
  int         sel;
  logic [5:0] op, funct;
  logic       mem_ready, overflow;
  logic       rst_a, rst_b;

  always #5 clk = ~clk;

  mips_mc_control_hs_if #(.ALUCTRL_W(3)) if_a ();
  mips_mc_control_hs_if #(.ALUCTRL_W(3)) if_b ();

  assign if_a.op = op;         assign if_b.op = op;
  assign if_a.funct = funct;   assign if_b.funct = funct;
  assign if_a.mem_ready = mem_ready; assign if_b.mem_ready = mem_ready;
  assign if_a.overflow = overflow;   assign if_b.overflow = overflow;
  assign rst_a = rst || (sel != 0);
  assign rst_b = rst || (sel != 1);

  mips_mc_control_hs #(.ALUCTRL_W(3), .WAIT_LIMIT(16), .EN_LOGIC_IMM(1), .TRAP_ILLEGAL(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(if_a.master));
  mips_mc_control_hs #(.ALUCTRL_W(3), .WAIT_LIMIT(4), .EN_LOGIC_IMM(1), .TRAP_ILLEGAL(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(if_b.master));

  typedef struct packed {
    logic       mem_req, MemWrite, IorD, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtSel, IRWrite, PCWrite, Branch, BranchNE;
    logic [1:0] PCSrc;
    logic       RegWrite, RegDst, MemtoReg;
    logic [2:0] ALUControl;
    logic       EPCWrite, illegal_op, bus_error;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    ctl_t  got;
    string tag;
  } rec_t;

  ctl_t obs_a, obs_b, obs;
  assign obs_a = {if_a.mem_req, if_a.MemWrite, if_a.IorD, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ExtSel,
                  if_a.IRWrite, if_a.PCWrite, if_a.Branch, if_a.BranchNE, if_a.PCSrc, if_a.RegWrite,
                  if_a.RegDst, if_a.MemtoReg, if_a.ALUControl, if_a.EPCWrite, if_a.illegal_op, if_a.bus_error};
  assign obs_b = {if_b.mem_req, if_b.MemWrite, if_b.IorD, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ExtSel,
                  if_b.IRWrite, if_b.PCWrite, if_b.Branch, if_b.BranchNE, if_b.PCSrc, if_b.RegWrite,
                  if_b.RegDst, if_b.MemtoReg, if_b.ALUControl, if_b.EPCWrite, if_b.illegal_op, if_b.bus_error};
  assign obs = (sel == 1) ? obs_b : obs_a;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   m_illegal, m_buserr;
  int   lim, trap_ill;
  int   force_ov = -1;
  rec_t trace[$];
  logic [5:0] op_pool[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F};
  logic [5:0] fn_pool[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.ALUControl = 3'b010;
    return c;
  endfunction

  // Apply one cycle of inputs, record what the controller shows against the model's expectation
  task automatic cyc(input logic mr, input logic ov, input ctl_t exp_in, input string tag);
    ctl_t e = exp_in;
    mem_ready = mr;
    overflow  = ov;
    e.illegal_op = m_illegal;
    e.bus_error  = m_buserr;
    #1;
    trace.push_back('{e, obs, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic use_dut(input int s);
    rst = 1'b1;
    sel = s;
    lim = (s == 1) ? 4 : 16;
    trap_ill = (s == 1) ? 0 : 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_illegal = 1'b0;
    m_buserr  = 1'b0;
  endtask

  task automatic do_trap();
    ctl_t e = idle();
    e.EPCWrite = 1'b1;
    e.PCSrc    = 2'b11;
    e.PCWrite  = 1'b1;
    cyc(rb(), rb(), e, "trap");
  endtask

  task automatic take_illegal();
    if (trap_ill != 0) begin
      m_illegal = 1'b1;
      do_trap();
    end
  endtask

  task automatic mem_phase(input int waits, input ctl_t busy, input ctl_t done, input string tag, output bit expired);
    expired = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (k == waits) cyc(1'b1, rb(), done, tag);
      else begin
        cyc(1'b0, rb(), busy, tag);
        if (lim != 0 && k == lim - 1) begin
          expired  = 1'b1;
          m_buserr = 1'b1;
          break;
        end
      end
    end
  endtask

  // One instruction from fetch to the cycle before the next fetch, as the ISA-level rules dictate
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    ctl_t e, d;
    bit exp, ok;
    logic ov;
    logic [2:0] code;
    op = o;
    funct = f;
    e = idle(); e.mem_req = 1'b1; e.ALUSrcB = 2'b01;
    d = e; d.IRWrite = 1'b1; d.PCWrite = 1'b1;
    mem_phase(fw, e, d, "fetch", exp);
    if (exp) begin
      do_trap();
      return;
    end
    e = idle(); e.ALUSrcB = 2'b11;
    cyc(rb(), rb(), e, "decode");
    ov = (force_ov < 0) ? rb() : (force_ov != 0);
    case (o)
      6'h23, 6'h2B: begin
        e = idle(); e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
        cyc(rb(), rb(), e, "memadr");
        e = idle(); e.IorD = 1'b1; e.mem_req = 1'b1; e.MemWrite = (o == 6'h2B);
        mem_phase(mw, e, e, (o == 6'h2B) ? "memwr" : "memrd", exp);
        if (exp) do_trap();
        else if (o == 6'h23) begin
          e = idle(); e.RegWrite = 1'b1; e.MemtoReg = 1'b1;
          cyc(rb(), rb(), e, "memwb");
        end
      end
      6'h00: begin
        ok = 1'b1;
        case (f)
          6'h20: code = 3'b010;
          6'h22: code = 3'b110;
          6'h24: code = 3'b000;
          6'h25: code = 3'b001;
          6'h2A: code = 3'b111;
          default: begin ok = 1'b0; code = 3'b010; end
        endcase
        e = idle(); e.ALUSrcA = 1'b1; e.ALUControl = code;
        cyc(rb(), rb(), e, "exec");
        if (!ok) take_illegal();
        else begin
          e = idle(); e.RegDst = 1'b1; e.RegWrite = !(f == 6'h20 && ov);
          cyc(rb(), ov, e, "aluwb");
          if (f == 6'h20 && ov) do_trap();
        end
      end
      6'h04, 6'h05: begin
        e = idle(); e.ALUSrcA = 1'b1; e.ALUControl = 3'b110; e.PCSrc = 2'b01;
        e.Branch = (o == 6'h04); e.BranchNE = (o == 6'h05);
        cyc(rb(), rb(), e, "branch");
      end
      6'h08, 6'h0C, 6'h0D: begin
        e = idle(); e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ExtSel = (o != 6'h08);
        e.ALUControl = (o == 6'h08) ? 3'b010 : (o == 6'h0C) ? 3'b000 : 3'b001;
        cyc(rb(), rb(), e, "iexec");
        e = idle(); e.RegWrite = !(o == 6'h08 && ov);
        cyc(rb(), ov, e, "iwb");
        if (o == 6'h08 && ov) do_trap();
      end
      6'h02: begin
        e = idle(); e.PCSrc = 2'b10; e.PCWrite = 1'b1;
        cyc(rb(), rb(), e, "jump");
      end
      default: take_illegal();
    endcase
  endtask

  task automatic test_reset();
    logic [7:0] en;
    ctl_t e;
    use_dut(0);
    run_instr(6'h23, 6'h00, 1, 20);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rb();
      #1;
      en = {obs.mem_req, obs.MemWrite, obs.IRWrite, obs.PCWrite, obs.Branch, obs.BranchNE, obs.RegWrite, obs.EPCWrite};
      n_checks++;
      if (en !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_enables: got %b required 00000000", en);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    e = idle(); e.mem_req = 1'b1; e.ALUSrcB = 2'b01;
    #1;
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, e);
    end
    trace.delete();
  endtask

  task automatic test_lw_wait();
    int nreg, nrd;
    use_dut(0);
    run_instr(6'h23, 6'h11, 0, 3);
    nreg = 0; nrd = 0;
    foreach (trace[i]) begin
      n_checks++;
      if (trace[i].got !== trace[i].exp) begin
        n_fail++;
        $display("FAIL lw_wait/%s: got %h required %h", trace[i].tag, trace[i].got, trace[i].exp);
      end
      nreg += int'(trace[i].got.RegWrite);
      nrd  += int'(trace[i].got.IorD && !trace[i].got.MemWrite);
    end
    n_checks++;
    if (nreg != 1 || nrd != 4) begin
      n_fail++;
      $display("FAIL lw_wait_counts: RegWrite cycles %0d MEMRD cycles %0d required 1 and 4", nreg, nrd);
    end
    trace.delete();
  endtask

  task automatic test_overflow_traps();
    use_dut(0);
    force_ov = 1;
    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h0D, 6'h00, 0, 0);
    run_instr(6'h0C, 6'h00, 1, 0);
    run_instr(6'h08, 6'h00, 0, 0);
    force_ov = 0;
    run_instr(6'h00, 6'h20, 0, 0);
    force_ov = -1;
    run_instr(6'h02, 6'h00, 0, 0);
    foreach (trace[i]) begin
      n_checks++;
      if (trace[i].got !== trace[i].exp) begin
        n_fail++;
        $display("FAIL overflow/%s: got %h required %h", trace[i].tag, trace[i].got, trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_illegal();
    use_dut(0);
    run_instr(6'h3F, 6'h00, 0, 0);
    run_instr(6'h00, 6'h3F, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    n_checks++;
    if (obs.illegal_op !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_flag_trap: got %b required 1", obs.illegal_op);
    end
    use_dut(1);
    run_instr(6'h3F, 6'h00, 0, 0);
    run_instr(6'h00, 6'h3F, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    n_checks++;
    if (obs.illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_flag_nop: got %b required 0", obs.illegal_op);
    end
    foreach (trace[i]) begin
      n_checks++;
      if (trace[i].got !== trace[i].exp) begin
        n_fail++;
        $display("FAIL illegal/%s: got %h required %h", trace[i].tag, trace[i].got, trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_watchdog();
    int nir;
    use_dut(1);
    run_instr(6'h02, 6'h00, 10, 0);
    nir = 0;
    foreach (trace[i]) nir += int'(trace[i].got.IRWrite);
    n_checks++;
    if (nir != 0 || obs.bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog_fetch: IRWrite cycles %0d bus_error %b required 0 and 1", nir, obs.bus_error);
    end
    use_dut(1);
    run_instr(6'h02, 6'h00, 3, 0);
    run_instr(6'h23, 6'h00, 0, 9);
    run_instr(6'h2B, 6'h00, 0, 3);
    run_instr(6'h2B, 6'h00, 0, 7);
    use_dut(0);
    run_instr(6'h2B, 6'h00, 20, 0);
    run_instr(6'h23, 6'h00, 15, 15);
    foreach (trace[i]) begin
      n_checks++;
      if (trace[i].got !== trace[i].exp) begin
        n_fail++;
        $display("FAIL watchdog/%s: got %h required %h", trace[i].tag, trace[i].got, trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_rst_mid_store();
    ctl_t e;
    use_dut(0);
    run_instr(6'h3F, 6'h00, 0, 0);
    op = 6'h2B;
    e = idle(); e.mem_req = 1'b1; e.ALUSrcB = 2'b01; e.IRWrite = 1'b1; e.PCWrite = 1'b1;
    cyc(1'b1, 1'b0, e, "fetch");
    e = idle(); e.ALUSrcB = 2'b11;
    cyc(1'b0, 1'b0, e, "decode");
    e = idle(); e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
    cyc(1'b0, 1'b0, e, "memadr");
    e = idle(); e.IorD = 1'b1; e.mem_req = 1'b1; e.MemWrite = 1'b1;
    cyc(1'b0, 1'b0, e, "memwr");
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs.MemWrite !== 1'b0 || obs.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_store: MemWrite %b mem_req %b required 0 0", obs.MemWrite, obs.mem_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_illegal = 1'b0;
    m_buserr  = 1'b0;
    run_instr(6'h02, 6'h00, 2, 0);
    foreach (trace[i]) begin
      n_checks++;
      if (trace[i].got !== trace[i].exp) begin
        n_fail++;
        $display("FAIL rst_store/%s: got %h required %h", trace[i].tag, trace[i].got, trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_random();
    logic [5:0] o, f;
    int fw, mw;
    for (int s = 0; s < 2; s++) begin
      use_dut(s);
      for (int n = 0; n < 120; n++) begin
        o = op_pool[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
        f = fn_pool[$urandom_range(0, 5)];
        if (f == 6'h00) f = 6'($urandom_range(0, 63));
        fw = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 18) : $urandom_range(0, 3);
        mw = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 18) : $urandom_range(0, 3);
        run_instr(o, f, fw, mw);
      end
      foreach (trace[i]) begin
        n_checks++;
        if (trace[i].got !== trace[i].exp) begin
          n_fail++;
          $display("FAIL random/%s dut%0d: got %h required %h", trace[i].tag, s, trace[i].got, trace[i].exp);
        end
      end
      trace.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 0;
    op = 6'h00;
    funct = 6'h00;
    mem_ready = 1'b0;
    overflow = 1'b0;
    test_reset();
    test_lw_wait();
    test_overflow_traps();
    test_illegal();
    test_watchdog();
    test_rst_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
